// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared definitions for the MEM-stage access unit.
//   - funct3 encodings for loads/stores
//   - access FSM state enum
//   - latched request record
//   - NOP_INSTRUCTION used by the pipeline registers on flush/reset
package mem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
    localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
    localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
    localparam logic [2:0] F3_BU = 3'd4;  // LBU
    localparam logic [2:0] F3_HU = 3'd5;  // LHU

    localparam logic [DATA_W-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_e;

    // Everything captured on IDLE->REQ; held stable until the next access.
    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        byte_enable;
        logic [2:0]        funct3;
        logic [1:0]        offset;
    } mem_req_t;

endpackage

// File: rtl/mem_access_unit_extender.sv
// load_data_extender: combinational load-result formatter.
//   rdata    in  DATA_W  raw word returned by the data RAM
//   offset   in  2       byte offset of the access within the word
//   funct3   in  3       access size / signedness
//   ext_data out DATA_W  selected byte/half, sign- or zero-extended
module load_data_extender
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (offset)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        // Halfwords are always aligned, so offset[1] alone picks the half.
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    ext_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   ext_data = {24'd0, sel_byte};
            F3_HU:   ext_data = {16'd0, sel_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//   MEM_memory_read/write, MEM_funct3, MEM_alu_result, MEM_read_data2
//                      in   memory-control fields from EX/MEM
//   pipeline_hold      in   another stage holds the MEM instruction
//   mem_stall          out  combinational stall while an access is in flight
//   mem_access_fault   out  combinational misaligned/illegal flag
//   MEM_load_data      out  registered extended load result
//   dmem_req_*/dmem_write/dmem_addr/dmem_wdata/dmem_byte_enable
//                      out  registered request channel to the data RAM
//   dmem_resp_valid/dmem_resp_rdata
//                      in   load response channel
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MEM_memory_read,
    input  logic            MEM_memory_write,
    input  logic [2:0]      MEM_funct3,
    input  logic [XLEN-1:0] MEM_alu_result,
    input  logic [XLEN-1:0] MEM_read_data2,
    input  logic            pipeline_hold,
    output logic            mem_stall,
    output logic            mem_access_fault,
    output logic [XLEN-1:0] MEM_load_data,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_byte_enable,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata
);

    mau_state_e      state_q, state_d;
    mem_req_t        req_q, req_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            req_present;
    logic            size_bad;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic [XLEN-1:0] ext_data;

    // ---------------- fault detection ----------------
    assign req_present = MEM_memory_read | MEM_memory_write;

    always_comb begin
        size_bad = 1'b0;
        case (MEM_funct3)
            F3_B, F3_BU: size_bad = 1'b0;
            F3_H, F3_HU: size_bad = MEM_alu_result[0];
            F3_W:        size_bad = |MEM_alu_result[1:0];
            default:     size_bad = 1'b1;
        endcase
    end

    assign mem_access_fault = req_present &
                              ((MEM_memory_read & MEM_memory_write) | size_bad);

    // ---------------- store lane alignment ----------------
    always_comb begin
        st_wdata = MEM_read_data2;
        st_be    = 4'b1111;
        if (MEM_memory_write) begin
            case (MEM_funct3)
                F3_B, F3_BU: begin
                    st_wdata = {4{MEM_read_data2[7:0]}};
                    st_be    = 4'b0001 << MEM_alu_result[1:0];
                end
                F3_H, F3_HU: begin
                    st_wdata = {2{MEM_read_data2[15:0]}};
                    st_be    = 4'b0011 << MEM_alu_result[1:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- load extension ----------------
    load_data_extender u_ext (
        .rdata    (dmem_resp_rdata),
        .offset   (req_q.offset),
        .funct3   (req_q.funct3),
        .ext_data (ext_data)
    );

    // ---------------- access FSM ----------------
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_valid_d = req_valid_q;
        load_data_d = load_data_q;
        mem_stall   = 1'b0;
        case (state_q)
            IDLE: begin
                // Responses arriving here are stale (e.g. after a reset
                // mid-access) and are deliberately not looked at.
                if (req_present && !mem_access_fault) begin
                    mem_stall         = 1'b1;
                    req_d.write       = MEM_memory_write;
                    req_d.addr        = {MEM_alu_result[XLEN-1:2], 2'b00};
                    req_d.wdata       = st_wdata;
                    req_d.byte_enable = st_be;
                    req_d.funct3      = MEM_funct3;
                    req_d.offset      = MEM_alu_result[1:0];
                    req_valid_d       = 1'b1;
                    state_d           = REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_q.write ? DONE : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dmem_resp_valid) begin
                    load_data_d = ext_data;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Stay parked while held so the same instruction, still
                // sitting in EX/MEM, is not issued a second time.
                if (!pipeline_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmem_req_valid   = req_valid_q;
    assign dmem_write       = req_q.write;
    assign dmem_addr        = req_q.addr;
    assign dmem_wdata       = req_q.wdata;
    assign dmem_byte_enable = req_q.byte_enable;
    assign MEM_load_data    = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_memory_read, MEM_memory_write;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_result, MEM_read_data2;
    logic        pipeline_hold;
    logic        mem_stall, mem_access_fault;
    logic [31:0] MEM_load_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_write;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .MEM_memory_read(MEM_memory_read), .MEM_memory_write(MEM_memory_write),
        .MEM_funct3(MEM_funct3), .MEM_alu_result(MEM_alu_result),
        .MEM_read_data2(MEM_read_data2), .pipeline_hold(pipeline_hold),
        .mem_stall(mem_stall), .mem_access_fault(mem_access_fault),
        .MEM_load_data(MEM_load_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        logic        fault;
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ebe;
        logic [31:0] eload;
        int          ready_lo, resp_dly, hold;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
    } exp_req_t;

    localparam int NV = 17;
    vec_t        vecs[NV];
    exp_req_t    sb_q[$];
    int          total = 0, bad = 0, handshakes = 0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        MEM_memory_read  = 1'b0;
        MEM_memory_write = 1'b0;
        MEM_funct3       = 3'd0;
        MEM_alu_result   = 32'h0;
        MEM_read_data2   = 32'h0;
        pipeline_hold    = 1'b0;
        dmem_req_ready   = 1'b0;
        dmem_resp_valid  = 1'b0;
        dmem_resp_rdata  = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_req_t e, f;
        int  cyc, stalls, wait_cnt, resp_cnt, held, hs_before, exp_stalls;
        bit  hs, done;
        @(negedge clk);
        MEM_memory_read  = v.rd;
        MEM_memory_write = v.wr;
        MEM_funct3       = v.f3;
        MEM_alu_result   = v.addr;
        MEM_read_data2   = v.sdata;
        pipeline_hold    = 1'b0;
        dmem_resp_valid  = 1'b0;
        dmem_req_ready   = (v.ready_lo == 0);
        #1;
        chk({tag, " fault"}, {31'd0, mem_access_fault}, {31'd0, v.fault});
        if (v.fault) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, " fault stall"}, {31'd0, mem_stall}, 32'd0);
                chk({tag, " fault req_valid"}, {31'd0, dmem_req_valid}, 32'd0);
                @(negedge clk); #1;
            end
            clear_inputs();
            return;
        end
        e = '{v.wr, v.eaddr, v.ewdata, v.ebe};
        sb_q.push_back(e);
        hs_before = handshakes;
        stalls = 0; wait_cnt = 0; resp_cnt = 0; held = 0; cyc = 0;
        hs = 0; done = 0;
        while (!done && cyc < 40) begin
            if (mem_stall) stalls++;
            dmem_resp_valid = 1'b0;
            if (dmem_req_valid) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " unexpected req"}, 32'd1, 32'd0);
                end else begin
                    f = sb_q[0];
                    chk({tag, " req addr"}, dmem_addr, f.addr);
                    chk({tag, " req write"}, {31'd0, dmem_write}, {31'd0, f.wr});
                    chk({tag, " req be"}, {28'd0, dmem_byte_enable}, {28'd0, f.be});
                    if (f.wr) chk({tag, " req wdata"}, dmem_wdata, f.wdata);
                    dmem_req_ready = (wait_cnt >= v.ready_lo);
                    wait_cnt++;
                    if (dmem_req_ready) begin
                        void'(sb_q.pop_front());
                        handshakes++;
                        hs = 1;
                    end
                end
            end else if (hs && mem_stall) begin
                dmem_req_ready = 1'b0;
                if (resp_cnt >= v.resp_dly) begin
                    dmem_resp_valid = 1'b1;
                    dmem_resp_rdata = v.rdata;
                end else begin
                    dmem_resp_rdata = ~v.rdata;
                end
                resp_cnt++;
            end else if (hs) begin
                dmem_req_ready = 1'b0;
                if (!v.wr && held == 0) last_load = v.eload;
                chk({tag, " load_data"}, MEM_load_data, last_load);
                if (held < v.hold) begin
                    pipeline_hold = 1'b1;
                    held++;
                end else begin
                    clear_inputs();
                    done = 1;
                end
            end
            cyc++;
            @(negedge clk); #1;
        end
        if (!done) chk({tag, " timeout"}, 32'd1, 32'd0);
        exp_stalls = 2 + v.ready_lo + (v.wr ? 0 : 1 + v.resp_dly);
        chk({tag, " stall cycles"}, stalls, exp_stalls);
        chk({tag, " request count"}, handshakes - hs_before, 32'd1);
        chk({tag, " idle stall"}, {31'd0, mem_stall}, 32'd0);
        chk({tag, " idle req_valid"}, {31'd0, dmem_req_valid}, 32'd0);
        chk({tag, " load_data kept"}, MEM_load_data, last_load);
    endtask

    // Reset asserted while a load waits for its response; the late response
    // must not resurrect the access or touch the load result.
    task automatic reset_in_wait();
        @(negedge clk);
        MEM_memory_read = 1'b1; MEM_funct3 = F3_B; MEM_alu_result = 32'h0000_2001;
        dmem_req_ready = 1'b1;
        @(negedge clk); #1;
        chk("rst req_valid in REQ", {31'd0, dmem_req_valid}, 32'd1);
        @(negedge clk); #1;
        chk("rst stall in WAIT", {31'd0, mem_stall}, 32'd1);
        chk("rst no req in WAIT", {31'd0, dmem_req_valid}, 32'd0);
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst async stall", {31'd0, mem_stall}, 32'd0);
        chk("rst async load_data", MEM_load_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0000_80FF;
        @(negedge clk); #1;
        dmem_resp_valid = 1'b0;
        chk("rst late resp load_data", MEM_load_data, 32'd0);
        chk("rst late resp stall", {31'd0, mem_stall}, 32'd0);
        chk("rst late resp req_valid", {31'd0, dmem_req_valid}, 32'd0);
        last_load = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        //            rd  wr  f3    addr          sdata         rdata         flt eaddr         ewdata        ebe      eload        rl rd h
        vecs[0]  = '{1'b0,1'b1,3'd0,32'h0000_1003,32'h0000_00AB,32'h0,        1'b0,32'h0000_1000,32'hABAB_ABAB,4'b1000,32'h0,        0,0,0};
        vecs[1]  = '{1'b1,1'b0,3'd0,32'h0000_2001,32'h0,        32'h0000_80FF,1'b0,32'h0000_2000,32'h0,        4'b1111,32'hFFFF_FF80,0,0,0};
        vecs[2]  = '{1'b1,1'b0,3'd4,32'h0000_2001,32'h0,        32'h0000_80FF,1'b0,32'h0000_2000,32'h0,        4'b1111,32'h0000_0080,0,0,0};
        vecs[3]  = '{1'b1,1'b0,3'd2,32'h0000_3002,32'h0,        32'h0,        1'b1,32'h0,        32'h0,        4'b0000,32'h0,        0,0,0};
        vecs[4]  = '{1'b0,1'b1,3'd1,32'h0000_1002,32'h1234_BEEF,32'h0,        1'b0,32'h0000_1000,32'hBEEF_BEEF,4'b1100,32'h0,        4,0,0};
        vecs[5]  = '{1'b1,1'b0,3'd1,32'h0000_4002,32'h0,        32'h8001_7FFF,1'b0,32'h0000_4000,32'h0,        4'b1111,32'hFFFF_8001,2,2,0};
        vecs[6]  = '{1'b1,1'b0,3'd5,32'h0000_4002,32'h0,        32'h8001_7FFF,1'b0,32'h0000_4000,32'h0,        4'b1111,32'h0000_8001,0,0,2};
        vecs[7]  = '{1'b0,1'b1,3'd2,32'h0000_5000,32'hDEAD_BEEF,32'h0,        1'b0,32'h0000_5000,32'hDEAD_BEEF,4'b1111,32'h0,        0,0,2};
        vecs[8]  = '{1'b1,1'b0,3'd2,32'h0000_6004,32'h0,        32'hCAFE_F00D,1'b0,32'h0000_6004,32'h0,        4'b1111,32'hCAFE_F00D,1,0,0};
        vecs[9]  = '{1'b0,1'b1,3'd1,32'h0000_7001,32'h0000_1111,32'h0,        1'b1,32'h0,        32'h0,        4'b0000,32'h0,        0,0,0};
        vecs[10] = '{1'b1,1'b0,3'd4,32'h0000_8003,32'h0,        32'h7F00_0000,1'b0,32'h0000_8000,32'h0,        4'b1111,32'h0000_007F,0,1,0};
        vecs[11] = '{1'b1,1'b0,3'd0,32'h0000_8003,32'h0,        32'h9A00_0000,1'b0,32'h0000_8000,32'h0,        4'b1111,32'hFFFF_FF9A,0,0,0};
        vecs[12] = '{1'b1,1'b0,3'd3,32'h0000_9000,32'h0,        32'h0,        1'b1,32'h0,        32'h0,        4'b0000,32'h0,        0,0,0};
        vecs[13] = '{1'b0,1'b1,3'd6,32'h0000_9000,32'h0,        32'h0,        1'b1,32'h0,        32'h0,        4'b0000,32'h0,        0,0,0};
        vecs[14] = '{1'b1,1'b1,3'd2,32'h0000_0000,32'h0,        32'h0,        1'b1,32'h0,        32'h0,        4'b0000,32'h0,        0,0,0};
        vecs[15] = '{1'b0,1'b1,3'd0,32'h0000_A002,32'hFFFF_FF55,32'h0,        1'b0,32'h0000_A000,32'h5555_5555,4'b0100,32'h0,        0,0,1};
        vecs[16] = '{1'b0,1'b1,3'd1,32'h0000_A000,32'hCAFE_1111,32'h0,        1'b0,32'h0000_A000,32'h1111_1111,4'b0011,32'h0,        1,0,0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", {31'd0, mem_stall}, 32'd0);
        chk("reset fault", {31'd0, mem_access_fault}, 32'd0);
        chk("reset load_data", MEM_load_data, 32'd0);
        chk("reset req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("reset write", {31'd0, dmem_write}, 32'd0);
        chk("reset addr", dmem_addr, 32'd0);
        chk("reset wdata", dmem_wdata, 32'd0);
        chk("reset be", {28'd0, dmem_byte_enable}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        reset_in_wait();
        run_vec(vecs[8], "post-reset lw");
        run_vec(vecs[0], "post-reset sb");

        chk("scoreboard empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit: the consumer of the EX/MEM pipeline register's memory-control fields (read/write strobes, funct3, ALU address, store data).
- Aligns store data into byte lanes with byte enables.
- Runs a valid/ready request plus response handshake to the data RAM.
- Sign- or zero-extends load data.
- Holds the pipeline through `mem_stall` while an access is outstanding.
- Flags misaligned or illegal accesses without touching memory.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MEM_memory_read`  in  1  load request from EX/MEM.
- `MEM_memory_write`  in  1  store request from EX/MEM.
- `MEM_funct3`  in  3  access size and signedness.
- `MEM_alu_result`  in  XLEN  byte address.
- `MEM_read_data2`  in  XLEN  store data.
- `pipeline_hold`  in  1  another stage is stalling; the MEM instruction will not advance this cycle.
- `mem_stall`  out  1  drives the EX/MEM stall and the upstream stalls.
- `mem_access_fault`  out  1  misaligned or illegal access, combinational.
- `MEM_load_data`  out  XLEN  extended load result, registered.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  RAM accepts request.
- `dmem_write`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  XLEN  word address, `{addr[31:2],2'b00}`.
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_byte_enable`  out  4  active lanes.
- `dmem_resp_valid`  in  1  load data valid.
- `dmem_resp_rdata`  in  XLEN  load word.

## Operation
Fault conditions:
- `mem_access_fault` = request present and any of:
  - read and write both set;
  - funct3 is 3, 6 or 7;
  - halfword with addr[0] set;
  - word with addr[1:0] ≠ 0.
- A faulting access never enters REQ and never stalls.

Store alignment:
- SB: wdata = {4{byte}}, byte_enable = 0001 << addr[1:0].
- SH: wdata = {2{half}}, byte_enable = 0011 << addr[1:0].
- SW: byte_enable = 1111.
- Loads drive byte_enable = 1111.

Load extension uses the latched offset:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word through.

FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - A legal request sets `mem_stall` combinationally.
  - It latches addr, wdata, byte_enable, funct3, offset and write.
  - Next state is REQ.
  - With no request, state stays IDLE and `dmem_resp_valid` is ignored.
- REQ:
  - `dmem_req_valid` = 1 and `mem_stall` = 1; request fields are held stable.
  - On `dmem_req_ready`: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - `mem_stall` = 1.
  - On `dmem_resp_valid`, the extended data is registered into `MEM_load_data`; next state is DONE.
- DONE:
  - `mem_stall` = 0 and `MEM_load_data` is valid.
  - If `pipeline_hold` = 1, state stays DONE, so the same instruction is not re-issued.
  - Otherwise next state is IDLE.

## Timing
- Reset: state IDLE and every output 0, including `MEM_load_data` = 0 and `dmem_req_valid` = 0.
- Reset mid-access: the request is abandoned, and a late `dmem_resp_valid` arriving in IDLE is ignored.
- `dmem_req_valid`, `dmem_write`, `dmem_addr`, `dmem_wdata` and `dmem_byte_enable` are registered.
- `mem_stall` and `mem_access_fault` are combinational.
- Store with ready held high: 2 stall cycles; the instruction advances at the end of the 3rd cycle (DONE).
- Load with ready high and response one cycle later: 3 stall cycles; advances at the end of DONE.
- `dmem_resp_valid` is sampled only in WAIT. The earliest valid response is the cycle after the request handshake.
- `MEM_load_data` holds its value until the next load completes; stores do not change it.
- The request fields change only on the IDLE→REQ transition.

## Structure
- Shared package holds:
  - funct3 constants: LB/SB 0, LH/SH 1, LW/SW 2, LBU 4, LHU 5;
  - the state enum;
  - the `NOP_INSTRUCTION` constant already used by the pipeline registers.
- Sub-module `load_data_extender` is combinational: rdata, offset and funct3 in; extended XLEN word out.
- Store alignment and fault checks stay inline.

## Test plan
- SB with addr 0x1003 and data 0x000000AB, ready high → addr 0x1000, wdata 0xABABABAB, byte_enable 1000, `mem_stall` high 2 cycles.
- LB at 0x2001, response word 0x0000_80FF → `MEM_load_data` 0xFFFFFF80. Same access as LBU → 0x00000080.
- LW at 0x3002 → `mem_access_fault` = 1, `dmem_req_valid` never asserts, `mem_stall` = 0.
- `dmem_req_ready` low for 4 cycles in REQ → request fields stable and `mem_stall` held; DONE reached 1 cycle after the response.
- `pipeline_hold` high for 2 cycles in DONE → exactly one memory request observed, with no re-issue.
- `reset` pulsed in WAIT, then `dmem_resp_valid` arrives → state IDLE, `MEM_load_data` = 0, response ignored.
